multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle control sequencer for the RV32I core datapath. It walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory, and selects the immediate-generator format. It also drives register-file write, ALU operand, write-back and PC-update selects from the instruction-register opcode, and counts retired instructions.

## Interface
- Parameters: none; widths come from the shared defines (`REG_WIDTH`=32, `IMM_GEN_OP_WIDTH`).
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ir  in  32  instruction register contents (datapath-owned, loaded on ir_we)
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- ir_we  out  1  load IR (and datapath old_pc) from imem data
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
- dmem_ack  in  1  data access complete this cycle
- branch_taken  in  1  branch comparator result, valid in EXEC
- imm_gen_op  out  IMM_GEN_OP_WIDTH  immediate format select (I/S/B/U/J/NONE)
- alu_a_sel  out  1  0 = rs1, 1 = old_pc
- alu_b_sel  out  1  0 = rs2, 1 = imm
- wb_sel  out  2  WB_ALU / WB_MEM / WB_PC4
- reg_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  PC_PC4 / PC_BR (old_pc+imm) / PC_JALR (alu & ~1)
- instret  out  32  retired-instruction count
- illegal  out  1  sticky illegal-opcode flag (only with CTRL_ILLEGAL_TRAP_EN)

## Operation
- Reset: state = IDLE, instret = 0, illegal = 0; all outputs 0, including imm_gen_op = IMM_GEN_NONE encoding.
- IDLE -> FETCH unconditionally.
- FETCH: imem_req = 1 until imem_ack is sampled high. In the ack cycle: ir_we = 1, next state DECODE.
- DECODE: imm_gen_op is decoded from ir[6:0]. Mapping:
  - OP-IMM/LOAD/JALR -> I
  - STORE -> S
  - BRANCH -> B
  - LUI/AUIPC -> U
  - JAL -> J
  - OP -> NONE
- imm_gen_op is held from DECODE to the end of the instruction, and is NONE in IDLE/FETCH.
- EXEC, by class:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR -> WB.
  - LOAD/STORE: compute address (alu_b_sel = 1) -> MEM.
  - BRANCH: pc_we = 1, pc_sel = PC_BR if branch_taken else PC_PC4 -> FETCH.
- MEM: dmem_req = 1 (dmem_we = 1 for STORE) until dmem_ack.
  - On ack, LOAD -> WB.
  - On ack, STORE -> FETCH with pc_we = 1, pc_sel = PC_PC4.
- WB: reg_we = 1 (suppressed if ir[11:7] = 0), pc_we = 1.
  - wb_sel: WB_MEM for LOAD, WB_PC4 for JAL/JALR, else WB_ALU.
  - pc_sel: PC_BR for JAL, PC_JALR for JALR, else PC_PC4.
  - Next state FETCH.
- FENCE/SYSTEM: DECODE -> FETCH with pc_we = 1, pc_sel = PC_PC4 (NOP).
- instret increments by 1 in every cycle with pc_we = 1 and wraps 0xFFFFFFFF -> 0.
- Outputs are combinational from state and ir[6:0]; only state, instret and illegal are registered.

## Timing
- Zero-wait latency per instruction:
  - ALU/U/J class: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - NOP class: 2 cycles.
- Each memory wait cycle adds 1 cycle. Ack in the same cycle as req is legal.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- req stays asserted while waiting, and is never dropped before ack.
- pc_we and reg_we are exactly 1 cycle per instruction; pc_we asserts exactly once per instruction.
- Asserting rst_n low in any state, including mid-handshake, forces all outputs to 0 immediately (asynchronous). Restart is IDLE -> FETCH.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An opcode outside the RV32I set, or ir[1:0] != 2'b11, moves DECODE to TRAP.
  - TRAP is absorbing until reset: illegal = 1 (sticky), all strobes 0, no further imem_req, instret frozen.
- Undefined: illegal is tied to 0, and such opcodes execute as the NOP class.

## Structure
- Shared defines file gains: state encodings, opcode constants, WB_* and PC_* codes, and `IMM_GEN_NONE`. These sit alongside the existing `IMM_GEN_*` codes.
- One combinational sub-module, ctrl_decode: ir[6:0] -> instruction class, imm_gen_op, alu_a_sel/alu_b_sel. The FSM and counter stay in multi_cycle_ctrl.

## Test plan
- Reset release with imem_ack = 0 -> all outputs 0, one IDLE cycle, then imem_req = 1 held until ack; instret = 0.
- ADDI x1,x0,5 (0x00500093), ack in the first FETCH cycle -> done in 4 cycles:
  - imm_gen_op = I, alu_b_sel = 1.
  - In the WB cycle: reg_we = 1, wb_sel = WB_ALU, pc_sel = PC_PC4.
  - instret = 1.
- LW x2,0(x1) (0x0000A103), dmem_ack after 3 wait cycles -> dmem_req high for 4 cycles with dmem_we = 0, then WB with wb_sel = WB_MEM; total 8 cycles.
- BEQ x1,x2,+8 (0x00208463):
  - branch_taken = 1 -> EXEC pc_we = 1, pc_sel = PC_BR, imm_gen_op = B, no reg_we.
  - Repeat with branch_taken = 0 -> pc_sel = PC_PC4.
- Opcode 0x0000007F:
  - With CTRL_ILLEGAL_TRAP_EN -> illegal = 1, no imem_req for 20 cycles, instret unchanged.
  - Without it -> pc_we in DECODE, next FETCH begins.
- rst_n low during a MEM wait (dmem_req = 1) -> dmem_req = 0 with no clock edge, instret = 0. After release: IDLE, then FETCH.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// multi_cycle_ctrl_pkg
// Shared widths, select codes, opcodes, FSM states and instruction classes.
// Rev 1.0
// ============================================================================
package multi_cycle_ctrl_pkg;

  localparam int REG_WIDTH        = 32;
  localparam int IMM_GEN_OP_WIDTH = 3;

  // NONE is all-zero so that an idle controller drives every output low
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_NONE = 3'd0;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_I    = 3'd1;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_S    = 3'd2;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_B    = 3'd3;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_U    = 3'd4;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_J    = 3'd5;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PC4  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_JAL     = 3'd1,
    CLS_JALR    = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_NOP     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } cls_e;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// ctrl_decode
// Opcode -> instruction class, immediate format and ALU operand selects.
// Unknown opcodes become CLS_ILLEGAL only when CTRL_ILLEGAL_TRAP_EN is defined.
// Rev 1.0
// ============================================================================
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [6:0]                  opcode_i,
  output cls_e                        cls_o,
  output logic [IMM_GEN_OP_WIDTH-1:0] imm_gen_op_o,
  output logic                        alu_a_sel_o,
  output logic                        alu_b_sel_o
);

  always_comb begin
    cls_o        = CLS_NOP;
    imm_gen_op_o = IMM_GEN_NONE;
    alu_a_sel_o  = 1'b0;
    alu_b_sel_o  = 1'b0;
    case (opcode_i)
      OPC_OP_IMM: begin cls_o = CLS_ALU;    imm_gen_op_o = IMM_GEN_I; alu_b_sel_o = 1'b1; end
      OPC_OP:     begin cls_o = CLS_ALU; end
      OPC_LUI:    begin cls_o = CLS_ALU;    imm_gen_op_o = IMM_GEN_U; alu_b_sel_o = 1'b1; end
      OPC_AUIPC: begin
        cls_o        = CLS_ALU;
        imm_gen_op_o = IMM_GEN_U;
        alu_a_sel_o  = 1'b1;
        alu_b_sel_o  = 1'b1;
      end
      OPC_JAL: begin
        cls_o        = CLS_JAL;
        imm_gen_op_o = IMM_GEN_J;
        alu_a_sel_o  = 1'b1;
        alu_b_sel_o  = 1'b1;
      end
      OPC_JALR:   begin cls_o = CLS_JALR;   imm_gen_op_o = IMM_GEN_I; alu_b_sel_o = 1'b1; end
      OPC_LOAD:   begin cls_o = CLS_LOAD;   imm_gen_op_o = IMM_GEN_I; alu_b_sel_o = 1'b1; end
      OPC_STORE:  begin cls_o = CLS_STORE;  imm_gen_op_o = IMM_GEN_S; alu_b_sel_o = 1'b1; end
      OPC_BRANCH: begin cls_o = CLS_BRANCH; imm_gen_op_o = IMM_GEN_B; end
      OPC_FENCE,
      OPC_SYSTEM: begin cls_o = CLS_NOP; end
`ifdef CTRL_ILLEGAL_TRAP_EN
      default:    begin cls_o = CLS_ILLEGAL; end
`else
      default:    begin cls_o = CLS_NOP; end
`endif
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// multi_cycle_ctrl
// RV32I multi-cycle sequencer with memory handshakes and retired-instruction
// counter. Optional sticky illegal-opcode trap: CTRL_ILLEGAL_TRAP_EN.
// Rev 1.0
// ============================================================================
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REG_WIDTH-1:0]        ir,
  output logic                        imem_req,
  input  logic                        imem_ack,
  output logic                        ir_we,
  output logic                        dmem_req,
  output logic                        dmem_we,
  input  logic                        dmem_ack,
  input  logic                        branch_taken,
  output logic [IMM_GEN_OP_WIDTH-1:0] imm_gen_op,
  output logic                        alu_a_sel,
  output logic                        alu_b_sel,
  output logic [1:0]                  wb_sel,
  output logic                        reg_we,
  output logic                        pc_we,
  output logic [1:0]                  pc_sel,
  output logic [REG_WIDTH-1:0]        instret,
  output logic                        illegal
);

  state_e                        state_q, state_d;
  logic [REG_WIDTH-1:0]          instret_q, instret_d;
  cls_e                          cls;
  logic [IMM_GEN_OP_WIDTH-1:0]   dec_imm;
  logic                          dec_a_sel, dec_b_sel;
  logic                          in_instr;
  logic                          unused_ir_hi;

  assign unused_ir_hi = ^ir[REG_WIDTH-1:12];

  ctrl_decode u_decode (
    .opcode_i     (ir[6:0]),
    .cls_o        (cls),
    .imm_gen_op_o (dec_imm),
    .alu_a_sel_o  (dec_a_sel),
    .alu_b_sel_o  (dec_b_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Decoded selects are only meaningful once IR holds the current instruction
  assign in_instr = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                    (state_q == ST_MEM)    || (state_q == ST_WB);

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    wb_sel     = WB_ALU;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PC4;
    imm_gen_op = in_instr ? dec_imm   : IMM_GEN_NONE;
    alu_a_sel  = in_instr ? dec_a_sel : 1'b0;
    alu_b_sel  = in_instr ? dec_b_sel : 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          state_d = ST_TRAP;
        end else if (cls == CLS_NOP) begin
          pc_we   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_BR : PC_PC4;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ack) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we  = (ir[11:7] != 5'd0);
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_BR;   end
          CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
          default:  wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign instret_d = instret_q + {{(REG_WIDTH-1){1'b0}}, pc_we};
  assign instret   = instret_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if ((state_q == ST_DECODE) && (cls == CLS_ILLEGAL)) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multi_cycle_ctrl
// Self-checking bench: directed vector table, async-reset and trap sequences,
// and a random instruction stream checked against a per-instruction model.
// Rev 1.0
// ============================================================================
module tb_multi_cycle_ctrl;

  localparam logic [2:0] E_NONE = 3'd0, E_I = 3'd1, E_S = 3'd2, E_B = 3'd3, E_U = 3'd4, E_J = 3'd5;
  localparam logic [1:0] E_WB_ALU = 2'd0, E_WB_MEM = 2'd1, E_WB_PC4 = 2'd2;
  localparam logic [1:0] E_PC4 = 2'd0, E_BR = 2'd1, E_JALR = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we;
  logic [2:0]  imm_gen_op;
  logic        alu_a_sel, alu_b_sel, reg_we, pc_we, illegal;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .imm_gen_op(imm_gen_op),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .instret(instret), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    int          fw;
    int          mw;
    bit          tk;
    int          cycles;
    logic [1:0]  pc_sel;
    bit          reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  imm;
    bit          a_sel;
    bit          b_sel;
    int          dreqs;
    bit          dwe;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {16'h0, imem_req, ir_we, dmem_req, dmem_we, imm_gen_op, alu_a_sel, alu_b_sel,
            wb_sel, reg_we, pc_we, pc_sel, instret, illegal};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input int fw, input int mw, input bit tk,
                               input int cycles, input logic [1:0] ps, input bit rw,
                               input logic [1:0] ws, input logic [2:0] imm, input bit a,
                               input bit b, input int dreqs, input bit dwe);
    vec_t v;
    v.instr = instr; v.fw = fw; v.mw = mw; v.tk = tk; v.cycles = cycles; v.pc_sel = ps;
    v.reg_we = rw; v.wb_sel = ws; v.imm = imm; v.a_sel = a; v.b_sel = b;
    v.dreqs = dreqs; v.dwe = dwe;
    return v;
  endfunction

  // Expected per-instruction behaviour, straight from the opcode rules
  function automatic vec_t model(input logic [31:0] instr, input int fw, input int mw, input bit tk);
    vec_t v;
    bit   writer = 1'b0;
    v = mkv(instr, fw, mw, tk, 2, E_PC4, 1'b0, E_WB_ALU, E_NONE, 1'b0, 1'b0, 0, 1'b0);
    case (instr[6:0])
      7'h13: begin v.cycles = 4; v.imm = E_I; v.b_sel = 1; writer = 1; end
      7'h33: begin v.cycles = 4; writer = 1; end
      7'h37: begin v.cycles = 4; v.imm = E_U; v.b_sel = 1; writer = 1; end
      7'h17: begin v.cycles = 4; v.imm = E_U; v.a_sel = 1; v.b_sel = 1; writer = 1; end
      7'h6F: begin v.cycles = 4; v.imm = E_J; v.a_sel = 1; v.b_sel = 1; writer = 1;
                   v.wb_sel = E_WB_PC4; v.pc_sel = E_BR; end
      7'h67: begin v.cycles = 4; v.imm = E_I; v.b_sel = 1; writer = 1;
                   v.wb_sel = E_WB_PC4; v.pc_sel = E_JALR; end
      7'h03: begin v.cycles = 5 + mw; v.imm = E_I; v.b_sel = 1; writer = 1;
                   v.wb_sel = E_WB_MEM; v.dreqs = mw + 1; end
      7'h23: begin v.cycles = 4 + mw; v.imm = E_S; v.b_sel = 1; v.dreqs = mw + 1; v.dwe = 1; end
      7'h63: begin v.cycles = 3; v.imm = E_B; v.pc_sel = tk ? E_BR : E_PC4; end
      default: v.cycles = 2;
    endcase
    v.cycles += fw;
    v.reg_we = writer && (instr[11:7] != 5'd0);
    return v;
  endfunction

  // Entered and left at posedge+1 with the DUT in FETCH
  task automatic run_instr(input vec_t e, input string nm);
    int         cyc = 0, reqs = 0, dreqs = 0, pcw = 0, rw = 0, irw = 0;
    int         imm_bad = 0, sel_bad = 0, dwe_bad = 0;
    logic [1:0] psel = 2'd3, wsel = 2'd3;
    bit         fetched = 0, done = 0, load_now;
    logic [31:0] ret0 = instret;
    while (!done && cyc < e.cycles + 20) begin
      imem_ack     = fetched ? 1'($urandom_range(0, 1)) : (reqs == e.fw);
      dmem_ack     = (e.dreqs != 0) ? (dreqs == e.mw) : 1'($urandom_range(0, 1));
      branch_taken = e.tk;
      @(negedge clk);
      cyc++;
      if (imem_req) begin
        reqs++;
        if (imm_gen_op !== E_NONE) imm_bad++;
      end else if (fetched) begin
        if (imm_gen_op !== e.imm) imm_bad++;
        if ({alu_a_sel, alu_b_sel} !== {e.a_sel, e.b_sel}) sel_bad++;
      end
      load_now = ir_we;
      if (ir_we) irw++;
      if (dmem_req) begin dreqs++; if (dmem_we !== e.dwe) dwe_bad++; end
      if (reg_we) begin rw++; wsel = wb_sel; end
      if (pc_we) begin pcw++; psel = pc_sel; done = 1; end
      @(posedge clk); #1;
      if (load_now) begin ir = e.instr; fetched = 1; end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk({nm, " completes"}, 64'(done), 64'd1);
    chk({nm, " cycles"}, 64'(cyc), 64'(e.cycles));
    chk({nm, " imem_req cycles"}, 64'(reqs), 64'(e.fw + 1));
    chk({nm, " ir_we count"}, 64'(irw), 64'd1);
    chk({nm, " dmem_req cycles"}, 64'(dreqs), 64'(e.dreqs));
    chk({nm, " pc_we count"}, 64'(pcw), 64'd1);
    chk({nm, " pc_sel"}, 64'(psel), 64'(e.pc_sel));
    chk({nm, " reg_we count"}, 64'(rw), 64'(e.reg_we));
    if (e.reg_we) chk({nm, " wb_sel"}, 64'(wsel), 64'(e.wb_sel));
    chk({nm, " imm_gen_op errors"}, 64'(imm_bad), 64'd0);
    chk({nm, " alu sel errors"}, 64'(sel_bad), 64'd0);
    chk({nm, " dmem_we errors"}, 64'(dwe_bad), 64'd0);
    chk({nm, " instret"}, 64'(instret), 64'(ret0 + 32'd1));
  endtask

  logic [6:0] legal_ops [11] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67,
                                 7'h03, 7'h23, 7'h63, 7'h0F, 7'h73};
  logic [6:0] bad_ops [3] = '{7'h7F, 7'h0B, 7'h02};

  initial begin
    logic [31:0] r;
    logic [31:0] saved;
    int          reqs, pcs;

    //              instr        fw mw tk cyc ps      rw ws        imm    a  b  dq dwe
    vecs.push_back(mkv(32'h00500093, 0, 0, 0, 4, E_PC4,  1, E_WB_ALU, E_I,    0, 1, 0, 0)); // ADDI
    vecs.push_back(mkv(32'h0000A103, 0, 3, 0, 8, E_PC4,  1, E_WB_MEM, E_I,    0, 1, 4, 0)); // LW
    vecs.push_back(mkv(32'h00208463, 0, 0, 1, 3, E_BR,   0, E_WB_ALU, E_B,    0, 0, 0, 0)); // BEQ taken
    vecs.push_back(mkv(32'h00208463, 0, 0, 0, 3, E_PC4,  0, E_WB_ALU, E_B,    0, 0, 0, 0)); // BEQ not
    vecs.push_back(mkv(32'h0020A223, 0, 0, 0, 4, E_PC4,  0, E_WB_ALU, E_S,    0, 1, 1, 1)); // SW
    vecs.push_back(mkv(32'h0020A223, 1, 2, 0, 7, E_PC4,  0, E_WB_ALU, E_S,    0, 1, 3, 1)); // SW waits
    vecs.push_back(mkv(32'h010000EF, 0, 0, 0, 4, E_BR,   1, E_WB_PC4, E_J,    1, 1, 0, 0)); // JAL
    vecs.push_back(mkv(32'h00008067, 0, 0, 0, 4, E_JALR, 0, E_WB_PC4, E_I,    0, 1, 0, 0)); // JALR x0
    vecs.push_back(mkv(32'h123452B7, 0, 0, 0, 4, E_PC4,  1, E_WB_ALU, E_U,    0, 1, 0, 0)); // LUI
    vecs.push_back(mkv(32'h00001197, 0, 0, 0, 4, E_PC4,  1, E_WB_ALU, E_U,    1, 1, 0, 0)); // AUIPC
    vecs.push_back(mkv(32'h002081B3, 0, 0, 0, 4, E_PC4,  1, E_WB_ALU, E_NONE, 0, 0, 0, 0)); // ADD
    vecs.push_back(mkv(32'h0000000F, 0, 0, 0, 2, E_PC4,  0, E_WB_ALU, E_NONE, 0, 0, 0, 0)); // FENCE
    vecs.push_back(mkv(32'h00000073, 0, 0, 0, 2, E_PC4,  0, E_WB_ALU, E_NONE, 0, 0, 0, 0)); // ECALL
    vecs.push_back(mkv(32'h00500093, 2, 0, 0, 6, E_PC4,  1, E_WB_ALU, E_I,    0, 1, 0, 0)); // ADDI fw2
    vecs.push_back(mkv(32'h0000A003, 0, 0, 0, 5, E_PC4,  0, E_WB_MEM, E_I,    0, 1, 1, 0)); // LW x0
`ifndef CTRL_ILLEGAL_TRAP_EN
    vecs.push_back(mkv(32'h0000007F, 0, 0, 0, 2, E_PC4,  0, E_WB_ALU, E_NONE, 0, 0, 0, 0)); // bad op
`endif

    // Reset state and release with no fetch ack
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fetch req held", 64'(imem_req), 64'd1);
      @(posedge clk); #1;
    end
    chk("instret after reset", 64'(instret), 64'd0);

    for (int i = 0; i < vecs.size(); i++) run_instr(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset during a data-memory wait
    imem_ack = 1'b1;
    @(posedge clk); #1;
    ir = 32'h0000A103;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mem wait dmem_req", 64'(dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dmem_req", 64'(dmem_req), 64'd0);
    chk("async reset outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart idle", 64'(imem_req), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart fetch", 64'(imem_req), 64'd1);
    @(posedge clk); #1;

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      r = $urandom;
      r[6:0] = legal_ops[$urandom_range(0, 10)];
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) r[6:0] = bad_ops[$urandom_range(0, 2)];
`endif
      if ($urandom_range(0, 5) == 0) r[11:7] = 5'd0;
      run_instr(model(r, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1))),
                $sformatf("rnd%0d", n));
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode traps and freezes the sequencer
    imem_ack = 1'b1;
    @(posedge clk); #1;
    ir = 32'h0000007F;
    imem_ack = 1'b0;
    saved = instret;
    @(posedge clk); #1;
    reqs = 0;
    pcs = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (imem_req) reqs++;
      if (pc_we) pcs++;
      @(posedge clk); #1;
    end
    chk("trap illegal", 64'(illegal), 64'd1);
    chk("trap no imem_req", 64'(reqs), 64'd0);
    chk("trap no pc_we", 64'(pcs), 64'd0);
    chk("trap instret frozen", 64'(instret), 64'(saved));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
